// File: rtl/onehot_dec_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : onehot_dec_stream
//  Purpose  : Streaming binary-to-one-hot decoder. N-bit codes enter over a
//             valid/ready handshake and are buffered in a 2-entry FIFO. Each
//             code leaves as a 2**N one-hot word over valid/ready, with the
//             binary code echoed alongside. A built-in SWEEP mode emits every
//             code 0..M-1 in ascending order.
//
//  Ports    :
//    clk          in   1  clock, rising edge
//    rst_n        in   1  asynchronous active-low reset
//    in_code      in   N  binary code to decode
//    in_valid     in   1  in_code valid
//    in_ready     out  1  block can accept in_code this cycle
//    sweep_start  in   1  request a full 0..M-1 sweep (sampled in IDLE only)
//    out_onehot   out  M  decoded word, bit[code]=1; zero when out_valid=0
//    out_code     out  N  binary code of the current out_onehot
//    out_valid    out  1  out_onehot/out_code valid
//    out_ready    in   1  consumer accepts output this cycle
//    busy         out  1  sweep in progress (SWEEP or DRAIN)
//    sweep_done   out  1  one-cycle pulse when a sweep has fully drained
//
//  Revision : 1.0  initial release
// ============================================================================
module onehot_dec_stream #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_code,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         sweep_start,
    output logic [M-1:0] out_onehot,
    output logic [N-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         sweep_done
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter check: the one-hot width must cover exactly
    // every code value.
    // ------------------------------------------------------------------------
    if (M != (1 << N)) begin : g_bad_width
        $error("onehot_dec_stream: M must equal 2**N");
    end

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [N-1:0] c_last_code = N'(M - 1);
    localparam logic [N-1:0] c_code_one  = N'(1);
    localparam logic [1:0]   c_fifo_full = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [1:0]          count_q,     count_d;
    logic                head_q,      head_d;
    logic                tail_q,      tail_d;
    logic [1:0][N-1:0]   mem_q,       mem_d;
    logic [N-1:0]        sweep_cnt_q, sweep_cnt_d;
    logic                in_ready_q,  in_ready_d;

    logic                w_push;
    logic                w_pop;
    logic [N-1:0]        w_push_data;
    logic                w_out_valid;

    // ------------------------------------------------------------------------
    // Next-state logic: FSM, push source selection and FIFO bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        w_push      = 1'b0;
        w_push_data = in_code;

        w_out_valid = (count_q != 2'd0);
        w_pop       = w_out_valid && out_ready;

        case (state_q)
            ST_IDLE: begin
                // External input is taken even in the cycle sweep_start is
                // seen, so that code leaves ahead of the sweep codes.
                w_push      = in_valid && in_ready_q;
                w_push_data = in_code;
                if (sweep_start) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                end
            end

            ST_SWEEP: begin
                // Space is judged on the pre-pop count: a full FIFO is never
                // refilled in the same cycle it drains.
                if (count_q != c_fifo_full) begin
                    w_push      = 1'b1;
                    w_push_data = sweep_cnt_q;
                    sweep_cnt_d = sweep_cnt_q + c_code_one;
                    if (sweep_cnt_q == c_last_code) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (count_q == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // FIFO pointers and storage
        head_d = head_q ^ w_pop;
        tail_d = tail_q ^ w_push;
        mem_d  = mem_q;
        if (w_push) begin
            mem_d[tail_q] = w_push_data;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Registered ready: reads low throughout reset and for the first edge
        // after release, then tracks IDLE with space in the FIFO.
        in_ready_d = (state_d == ST_IDLE) && (count_d != c_fifo_full);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 2'd0;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            mem_q       <= '0;
            sweep_cnt_q <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            mem_q       <= mem_d;
            sweep_cnt_q <= sweep_cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registers or the FIFO head entry
    // ------------------------------------------------------------------------
    assign in_ready   = in_ready_q;
    assign out_valid  = w_out_valid;
    assign out_code   = mem_q[head_q];
    assign out_onehot = w_out_valid ? (M'(1) << out_code) : '0;
    assign busy       = (state_q != ST_IDLE);
    // DRAIN with an empty FIFO lasts exactly one cycle, as it always
    // returns to IDLE on the following edge.
    assign sweep_done = (state_q == ST_DRAIN) && (count_q == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_onehot_dec_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_dec_stream
//  Purpose  : Self-checking bench for onehot_dec_stream. A queue-based model
//             of the output stream predicts every output each cycle; directed
//             steps cover reset, single transfer, backpressure, sweeps and a
//             reset in the middle of a sweep.
//  Revision : 1.0  initial release
// ============================================================================
module tb_onehot_dec_stream;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_code;
    logic        in_valid;
    logic        in_ready;
    logic        sweep_start;
    logic [15:0] out_onehot;
    logic [3:0]  out_code;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        sweep_done;

    onehot_dec_stream #(.N(4), .M(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_code     (in_code),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sweep_start (sweep_start),
        .out_onehot  (out_onehot),
        .out_code    (out_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .sweep_done  (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    // Reference model: pending output codes, mode (0 idle, 1 sweeping,
    // 2 draining), next sweep code, and whether a clock edge has occurred
    // since reset release.
    int q[$];
    int mode    = 0;
    int sw      = 0;
    bit rdy_ok  = 0;

    // Observation logs
    int out_log[$];
    int done_cnt = 0;
    int busy_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int encode16(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Called at a falling edge with inputs already applied: compares the
    // outputs to the model, advances the model for the coming rising edge,
    // then moves on to the next falling edge.
    task automatic step();
        int sz;
        bit vld, erdy, pop, push;
        int pdata;
        sz   = q.size();
        vld  = (sz != 0);
        erdy = rdy_ok && (mode == 0) && (sz < 2);

        chk("out_valid",  {31'd0, out_valid}, {31'd0, vld});
        chk("out_onehot", {16'd0, out_onehot}, vld ? (32'd1 << q[0]) : 32'd0);
        if (vld) chk("out_code", {28'd0, out_code}, q[0]);
        chk("in_ready",   {31'd0, in_ready}, {31'd0, erdy});
        chk("busy",       {31'd0, busy}, {31'd0, mode != 0});
        chk("sweep_done", {31'd0, sweep_done}, {31'd0, (mode == 2) && (sz == 0)});

        if (out_valid && out_ready) out_log.push_back(int'(out_code));
        if (sweep_done) done_cnt++;
        if (in_valid && in_ready && busy) busy_acc++;

        pop   = vld && out_ready;
        push  = 0;
        pdata = 0;
        case (mode)
            0: begin
                if (in_valid && erdy) begin
                    push  = 1;
                    pdata = int'(in_code);
                end
                if (sweep_start) begin
                    mode = 1;
                    sw   = 0;
                end
            end
            1: begin
                if (sz < 2) begin
                    push  = 1;
                    pdata = sw;
                    if (sw == 15) mode = 2;
                    sw++;
                end
            end
            default: begin
                if (sz == 0) mode = 0;
            end
        endcase
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(pdata);
        rdy_ok = 1;

        @(posedge clk);
        @(negedge clk);
    endtask

    // Asserts reset a few ns after a falling edge (mid-cycle), checks the
    // asynchronous clear, then releases on the next falling edge.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_out_onehot", {16'd0, out_onehot}, 32'd0);
        chk("rst_out_code",   {28'd0, out_code}, 32'd0);
        chk("rst_in_ready",   {31'd0, in_ready}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_sweep_done", {31'd0, sweep_done}, 32'd0);
        q.delete();
        mode   = 0;
        sw     = 0;
        rdy_ok = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int first_cyc, last_cyc, done_cyc;
        bit did_rst;

        rst_n       = 1'b0;
        in_code     = 4'h0;
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        out_ready   = 1'b0;

        // ---- 1: reset state ------------------------------------------------
        @(negedge clk);
        chk("init_out_valid",  {31'd0, out_valid}, 32'd0);
        chk("init_out_onehot", {16'd0, out_onehot}, 32'd0);
        chk("init_in_ready",   {31'd0, in_ready}, 32'd0);
        chk("init_busy",       {31'd0, busy}, 32'd0);
        chk("init_sweep_done", {31'd0, sweep_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_release", {31'd0, in_ready}, 32'd1);

        // ---- 2: single transfer ------------------------------------------
        in_code   = 4'hA;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_onehot", {16'd0, out_onehot}, 32'h0400);
        chk("single_code",   {28'd0, out_code}, 32'hA);
        step();

        // ---- 3: backpressure ---------------------------------------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 4'h3;
        step();
        in_code = 4'h5;
        step();
        in_code = 4'h7;
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        step();
        out_ready = 1'b1;
        chk("bp_out0", {16'd0, out_onehot}, 32'h0008);
        step();
        chk("bp_out1", {16'd0, out_onehot}, 32'h0020);
        step();
        in_valid = 1'b0;
        chk("bp_out2", {16'd0, out_onehot}, 32'h0080);
        step();
        step();

        // ---- 4: full-speed sweep with encoder round trip -------------------
        out_log.delete();
        done_cnt    = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        first_cyc = -1; last_cyc = -1; done_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                chk("enc_roundtrip", encode16(out_onehot), {28'd0, out_code});
                if (first_cyc < 0) first_cyc = i;
                last_cyc = i;
            end
            if (sweep_done) done_cyc = i;
            step();
        end
        chk("sweep_count",       out_log.size(), 16);
        for (int k = 0; k < 16 && k < out_log.size(); k++)
            chk("sweep_order", out_log[k], k);
        chk("sweep_consecutive", last_cyc - first_cyc, 15);
        chk("sweep_done_once",   done_cnt, 1);
        chk("sweep_done_after",  done_cyc, last_cyc + 1);

        // ---- 5: sweep under random backpressure with input pressure --------
        out_log.delete();
        done_cnt    = 0;
        busy_acc    = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 300 && done_cnt == 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'b1;
            in_code   = 4'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rnd_done_once", done_cnt, 1);
        chk("rnd_count",     out_log.size(), 16);
        for (int k = 0; k < 16 && k < out_log.size(); k++)
            chk("rnd_order", out_log[k], k);
        chk("rnd_no_input_while_busy", busy_acc, 0);
        step();
        step();

        // ---- 6: reset in the middle of a sweep -----------------------------
        done_cnt    = 0;
        did_rst     = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int i = 0; i < 40 && !did_rst; i++) begin
            if (out_valid && out_code == 4'h7) begin
                chk("mid_enc", encode16(out_onehot), 32'd7);
                reset_pulse();
                did_rst = 1;
            end else begin
                step();
            end
        end
        chk("mid_reset_reached", {31'd0, did_rst}, 32'd1);
        for (int i = 0; i < 30; i++) step();
        chk("mid_no_sweep_done", done_cnt, 0);
        chk("mid_idle_busy",     {31'd0, busy}, 32'd0);

        // A normal transfer still works after the aborted sweep.
        in_code  = 4'hC;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_reset_onehot", {16'd0, out_onehot}, 32'h1000);
        step();
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
